sort_feeder: RTL and testbench
==============================

// Module: sort_feeder
// PURPOSE
//  Upstream sequencer for the 8-entry, 4-bit bubble sorter.
//  - Buffers nibbles from a valid/ready source.
//  - Presents each batch of 8 nibbles to the sorter and drives its Load, Sort and Send strobes.
//  - Flags the 8 cycles in which the sorter's Data_out is valid.
//  Sits between the nibble source and the sorter. Top level inverts rst for the sorter's active-high reset.
// PARAMETERS
//  W        4    data width (must match sorter)
//  N        8    batch size (must match sorter array depth)
//  DEPTH    16   input FIFO entries (power of 2, >= N)
//  SORT_TMO 255  max cycles waiting for sorter Waiting before sort_err
// PORTS
//  clk             in   1  rising-edge clock
//  rst             in   1  asynchronous, active-low reset (0 = reset)
//  in_valid        in   1  source nibble valid
//  in_data         in   W  source nibble
//  in_ready        out  1  FIFO can accept (= !full)
//  sorter_ready    in   1  sorter Ready (sorter in idle)
//  sorter_waiting  in   1  sorter Waiting (sort complete, holding)
//  load            out  1  to sorter Load
//  sort            out  1  to sorter Sort
//  send            out  1  to sorter Send
//  data_to_sorter  out  W  to sorter Data_in
//  drain_req       in   1  downstream ready to take 8 sorted nibbles
//  out_valid       out  1  sorter Data_out valid this cycle
//  sort_err        out  1  sticky: sort timeout
//  batch_cnt       out  8  batches fully drained (wraps at 255->0)
// BEHAVIOUR
//  Reset values
//   - All outputs 0, except in_ready=1.
//   - FIFO emptied; FSM in FILL.
//   - Reset mid-batch abandons the batch. No partial replay.
//  FIFO: push on in_valid&in_ready; pop on load-phase cycles. Push while full is impossible (in_ready=0).
//   Simultaneous push/pop keeps count unchanged.
//  FSM (registered state; outputs decoded from state and counters):
//   - FILL: if count>=N && sorter_ready -> LOAD. Otherwise stay.
//   - LOAD: load=1, data_to_sorter=FIFO head, pop every cycle for exactly N cycles (ld_cnt 0..N-1).
//     First LOAD cycle coincides with sorter idle. Then -> SETTLE.
//   - SETTLE: wait for sorter_ready (sorter passes init->idle, 2 cycles), then -> SORT.
//   - SORT: sort=1 for exactly 1 cycle (load=0 this cycle; the sorter gives Load priority). Then -> BUSY.
//   - BUSY: wait for sorter_waiting, tmo counter running.
//     -> SEND when sorter_waiting && drain_req. Stay otherwise.
//     If tmo reaches SORT_TMO: set sort_err, -> FILL.
//   - SEND: send=1 for 1 cycle (cycle t). -> DRAIN.
//   - DRAIN: out_valid=1 for cycles t+1..t+N (sorter registers Data_out). On last cycle: batch_cnt++, -> FILL.
//  Output order: sorter emits A[N] first, so output is descending.
//  drain_req is sampled only in BUSY. Deasserting it later does not stall DRAIN.
//  Source may keep pushing during LOAD..DRAIN. The next batch starts only after returning to FILL.
//  sort_err clears only on reset.
//  Counters: ld_cnt and dr_cnt are clog2(N)+1 bits. tmo is 8 bits, saturating.
// STRUCTURE
//  Shared package/header:
//   - state encodings S_FILL..S_DRAIN (3 bits)
//   - W, N constants shared with sorter
//  One sub-module: sync_fifo (W x DEPTH). Outputs: count, full, empty. Head visible combinationally.
//  All other logic, FSM and counters stay in sort_feeder.
// TESTING (bench instantiates the real sorter)
//  1. Push 3,1,4,1,5,9,2,6 with drain_req=1.
//     -> load high 8 consecutive cycles, then one sort pulse, then one send.
//     -> out_valid 8 cycles carrying 9,6,5,4,3,2,1,1; batch_cnt=1.
//  2. Push 7 nibbles only -> stays in FILL, load never asserted. Push 8th -> LOAD starts next cycle.
//  3. Push 16 nibbles back-to-back (two batches).
//     -> in_ready drops at 16 entries.
//     -> two batches emitted in push order, each sorted descending; batch_cnt=2.
//  4. Hold drain_req=0 after sort completes.
//     -> remains in BUSY, send=0, sorter holds Waiting.
//     -> Raise drain_req -> send pulse next cycle, 8 outputs follow.
//  5. Tie sorter_waiting=0 (stub sorter) -> sort_err=1 after 255 BUSY cycles, FSM back in FILL.
//  6. Assert rst low during LOAD cycle 4 -> all outputs 0, in_ready=1, FIFO empty, FSM in FILL.
//     Deassert and push a fresh batch -> normal result.

Source files
------------

// File: rtl/sort_feeder_pkg.sv
// sort_feeder_pkg
//  Shared constants and FSM state encoding for the sort_feeder block.
//  W and N must match the downstream 8-entry, 4-bit bubble sorter.
package sort_feeder_pkg;

  localparam int W            = 4;    // nibble width, must match the sorter
  localparam int N            = 8;    // batch size, must match the sorter depth
  localparam int FIFO_DEPTH   = 16;   // input FIFO entries (power of 2, >= N)
  localparam int SORT_TMO_MAX = 255;  // BUSY cycles tolerated without Waiting

  typedef enum logic [2:0] {
    S_FILL   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_SORT   = 3'd3,
    S_BUSY   = 3'd4,
    S_SEND   = 3'd5,
    S_DRAIN  = 3'd6
  } state_t;

endpackage

// File: rtl/sort_feeder_if.sv
// sort_feeder_if
//  Valid/ready nibble stream from the source into sort_feeder.
//  Signals:
//   valid  source has a nibble this cycle
//   data   the nibble
//   ready  sink can accept (a transfer happens on valid & ready)
//  Modports: master = nibble source, slave = sort_feeder.
interface sort_feeder_if import sort_feeder_pkg::*; #(
  parameter int DW = W
) ();
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sort_feeder_fifo.sv
// sync_fifo
//  Single-clock FIFO buffering source nibbles ahead of the sorter.
//  Ports:
//   clk, rst_n  clock, asynchronous active-low reset (empties the FIFO)
//   i_push      write request (ignored while full)
//   i_data      write data
//   i_pop       read request (ignored while empty)
//   o_head      oldest entry, visible combinationally
//   o_count     number of stored entries (0..DEPTH)
//   o_full      count == DEPTH
//   o_empty     count == 0
module sync_fifo #(
  parameter int DW    = 4,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_data,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sort_feeder.sv
// sort_feeder
//  Upstream sequencer for the 8-entry, 4-bit bubble sorter. Buffers source
//  nibbles, hands each batch of N to the sorter with Load, then strobes Sort
//  and Send, and flags the N cycles in which the sorter's Data_out is valid.
//  Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   src                nibble stream in (sort_feeder_if.slave)
//   i_sorter_ready     sorter idle
//   i_sorter_waiting   sorter finished, holding result
//   o_load/o_sort/o_send  sorter strobes
//   o_data_to_sorter   sorter Data_in (FIFO head during load, else 0)
//   i_drain_req        downstream can take a sorted batch (sampled in BUSY)
//   o_out_valid        sorter Data_out valid this cycle
//   o_sort_err         sticky sort timeout
//   o_batch_cnt        batches fully drained, wraps
module sort_feeder import sort_feeder_pkg::*; #(
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int SORT_TMO = SORT_TMO_MAX
) (
  input  logic                clk,
  input  logic                rst_n,
  sort_feeder_if.slave        src,
  input  logic                i_sorter_ready,
  input  logic                i_sorter_waiting,
  output logic                o_load,
  output logic                o_sort,
  output logic                o_send,
  output logic [W-1:0]        o_data_to_sorter,
  input  logic                i_drain_req,
  output logic                o_out_valid,
  output logic                o_sort_err,
  output logic [7:0]          o_batch_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int KW = $clog2(N) + 1;

  state_t        r_state;
  logic          r_load;
  logic          r_sort;
  logic          r_send;
  logic          r_out_valid;
  logic          r_sort_err;
  logic [KW-1:0] r_ld_cnt;
  logic [KW-1:0] r_dr_cnt;
  logic [7:0]    r_tmo;
  logic [7:0]    r_batch_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic [CW-1:0] w_count;
  logic [W-1:0]  w_head;

  assign w_pop     = (r_state == S_LOAD) && !w_empty;
  assign src.ready = !w_full;

  sync_fifo #(
    .DW    (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (src.valid),
    .i_data  (src.data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The head is masked outside load so Data_in reads 0 after reset,
  // when the head slot holds stale contents.
  assign o_data_to_sorter = r_load ? w_head : '0;
  assign o_load           = r_load;
  assign o_sort           = r_sort;
  assign o_send           = r_send;
  assign o_out_valid      = r_out_valid;
  assign o_sort_err       = r_sort_err;
  assign o_batch_cnt      = r_batch_cnt;

  // Strobes are set on the transition into their state, so each is high
  // exactly while the FSM sits in it. The timeout only runs while the
  // sorter has not yet reported Waiting, so a held drain_req=0 never trips it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FILL;
      r_load      <= 1'b0;
      r_sort      <= 1'b0;
      r_send      <= 1'b0;
      r_out_valid <= 1'b0;
      r_sort_err  <= 1'b0;
      r_ld_cnt    <= '0;
      r_dr_cnt    <= '0;
      r_tmo       <= '0;
      r_batch_cnt <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_count >= CW'(N) && i_sorter_ready) begin
            r_state  <= S_LOAD;
            r_load   <= 1'b1;
            r_ld_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (r_ld_cnt == KW'(N - 1)) begin
            r_state <= S_SETTLE;
            r_load  <= 1'b0;
          end else begin
            r_ld_cnt <= r_ld_cnt + KW'(1);
          end
        end
        S_SETTLE: begin
          if (i_sorter_ready) begin
            r_state <= S_SORT;
            r_sort  <= 1'b1;
          end
        end
        S_SORT: begin
          r_sort  <= 1'b0;
          r_tmo   <= '0;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          if (i_sorter_waiting && i_drain_req) begin
            r_state <= S_SEND;
            r_send  <= 1'b1;
          end else if (!i_sorter_waiting) begin
            if (r_tmo == 8'(SORT_TMO - 1)) begin
              r_sort_err <= 1'b1;
              r_state    <= S_FILL;
            end else if (r_tmo != 8'hFF) begin
              r_tmo <= r_tmo + 8'd1;
            end
          end
        end
        S_SEND: begin
          r_send      <= 1'b0;
          r_out_valid <= 1'b1;
          r_dr_cnt    <= '0;
          r_state     <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_dr_cnt == KW'(N - 1)) begin
            r_out_valid <= 1'b0;
            r_batch_cnt <= r_batch_cnt + 8'd1;
            r_state     <= S_FILL;
          end else begin
            r_dr_cnt <= r_dr_cnt + KW'(1);
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_feeder.sv
// tb_sort_feeder
//  Drives sort_feeder with directed and random nibble batches and a
//  behavioural stand-in for the bubble sorter, and checks load order,
//  strobe counts, out_valid alignment, timeout and reset behaviour.
module tb_sort_feeder;
  import sort_feeder_pkg::*;

  typedef logic [N-1:0][W-1:0] nibVec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sort_feeder_if #(.DW(W)) src ();

  logic         sorterReady;
  logic         sorterWaiting;
  logic         dutLoad;
  logic         dutSort;
  logic         dutSend;
  logic [W-1:0] toSorter;
  logic         drainReq;
  logic         dutOutValid;
  logic         sortErr;
  logic [7:0]   batchCnt;

  sort_feeder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .src              (src),
    .i_sorter_ready   (sorterReady),
    .i_sorter_waiting (sorterWaiting),
    .o_load           (dutLoad),
    .o_sort           (dutSort),
    .o_send           (dutSend),
    .o_data_to_sorter (toSorter),
    .i_drain_req      (drainReq),
    .o_out_valid      (dutOutValid),
    .o_sort_err       (sortErr),
    .o_batch_cnt      (batchCnt)
  );

  int checks = 0;
  int errors = 0;

  // Sorter stand-in: idle -> load -> 2-cycle init -> idle -> sorting ->
  // waiting -> registered output of N values, largest first.
  localparam int M_IDLE = 0, M_LOAD = 1, M_INIT = 2, M_SORT = 3, M_WAIT = 4, M_OUT = 5;
  int      mSt;
  int      mIdx;
  int      mCnt;
  nibVec_t mA;
  nibVec_t mSorted;
  logic [W-1:0] mDout;
  bit      stubMode = 1'b0;
  bit      blockReady = 1'b0;

  assign sorterReady   = (mSt == M_IDLE) && !blockReady;
  assign sorterWaiting = (mSt == M_WAIT) && !stubMode;

  function automatic nibVec_t descOf(input nibVec_t a);
    nibVec_t r;
    int k;
    r = '0;
    k = 0;
    for (int v = (1 << W) - 1; v >= 0; v--)
      for (int i = 0; i < N; i++)
        if (int'(a[i]) == v) begin
          r[k] = a[i];
          k++;
        end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mSt   <= M_IDLE;
      mIdx  <= 0;
      mCnt  <= 0;
      mDout <= '0;
    end else begin
      case (mSt)
        M_IDLE: if (dutLoad) begin
                  mA[0] <= toSorter;
                  mIdx  <= 1;
                  mSt   <= M_LOAD;
                end else if (dutSort) begin
                  mCnt <= 0;
                  mSt  <= M_SORT;
                end
        M_LOAD: if (dutLoad && mIdx < N) begin
                  mA[mIdx] <= toSorter;
                  mIdx     <= mIdx + 1;
                end else begin
                  mCnt <= 0;
                  mSt  <= M_INIT;
                end
        M_INIT: begin
                  mCnt <= mCnt + 1;
                  if (mCnt == 1) mSt <= M_IDLE;
                end
        M_SORT: begin
                  mCnt <= mCnt + 1;
                  if (mCnt == 9) begin
                    mSorted <= descOf(mA);
                    mSt     <= M_WAIT;
                  end
                end
        M_WAIT: if (dutSend) begin
                  mDout <= mSorted[0];
                  mIdx  <= 1;
                  mSt   <= M_OUT;
                end
        M_OUT:  if (mIdx < N) begin
                  mDout <= mSorted[mIdx];
                  mIdx  <= mIdx + 1;
                end else begin
                  mSt <= M_IDLE;
                end
        default: mSt <= M_IDLE;
      endcase
    end
  end

  // Monitor: records what the DUT presents, sampled mid-cycle.
  int loadedQ[$];
  int outQ[$];
  int runQ[$];
  int loadRun = 0;
  int sortCnt = 0;
  int sendCnt = 0;
  int expQ[$];

  always @(negedge clk) begin
    if (dutLoad) begin
      loadedQ.push_back(int'(toSorter));
      loadRun++;
    end else if (loadRun != 0) begin
      runQ.push_back(loadRun);
      loadRun = 0;
    end
    if (dutSort) sortCnt++;
    if (dutSend) sendCnt++;
    if (dutOutValid) outQ.push_back(int'(mDout));
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] v);
    int guard = 0;
    @(negedge clk);
    src.valid = 1'b1;
    src.data  = v;
    while (!src.ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("pushReady", int'(src.ready), 1);
    @(posedge clk);
    #1 src.valid = 1'b0;
    expQ.push_back(int'(v));
  endtask

  task automatic pushRandom(input int n);
    for (int i = 0; i < n; i++) applyStimulus(W'($urandom_range((1 << W) - 1, 0)));
  endtask

  task automatic waitBatchCnt(input int target, input string tag);
    int guard = 0;
    while (int'(batchCnt) != target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput(tag, int'(batchCnt), target);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " in_ready"}, int'(src.ready), 1);
    checkOutput({tag, " load"}, int'(dutLoad), 0);
    checkOutput({tag, " sort"}, int'(dutSort), 0);
    checkOutput({tag, " send"}, int'(dutSend), 0);
    checkOutput({tag, " out_valid"}, int'(dutOutValid), 0);
    checkOutput({tag, " sort_err"}, int'(sortErr), 0);
    checkOutput({tag, " batch_cnt"}, int'(batchCnt), 0);
    checkOutput({tag, " data"}, int'(toSorter), 0);
  endtask

  // Loaded nibbles must follow push order; each batch of outputs must be
  // that batch sorted largest first.
  task automatic compareRun(input string tag, input bit expectOut);
    int q[$];
    checkOutput({tag, " loadedLen"}, loadedQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < loadedQ.size(); i++)
      checkOutput({tag, " loadOrder"}, loadedQ[i], expQ[i]);
    if (expectOut) begin
      checkOutput({tag, " outLen"}, outQ.size(), expQ.size());
      for (int b = 0; b + N <= expQ.size(); b += N) begin
        q = {};
        for (int i = 0; i < N; i++) q.push_back(expQ[b + i]);
        q.rsort();
        for (int i = 0; i < N && b + i < outQ.size(); i++)
          checkOutput({tag, " outValue"}, outQ[b + i], q[i]);
      end
    end
    expQ.delete();
    loadedQ.delete();
    outQ.delete();
    runQ.delete();
  endtask

  initial begin
    int t1[N] = '{3, 1, 4, 1, 5, 9, 2, 6};
    int s0;
    int d0;
    int g;
    int k;
    int loadsBefore;

    src.valid = 1'b0;
    src.data  = '0;
    drainReq  = 1'b1;
    #1;
    checkIdleOutputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Test 1: the directed batch.
    $display("[TB] test 1: directed batch");
    s0 = sortCnt;
    d0 = sendCnt;
    for (int i = 0; i < N; i++) applyStimulus(W'(t1[i]));
    waitBatchCnt(1, "t1 batch_cnt");
    checkOutput("t1 loadRuns", runQ.size(), 1);
    if (runQ.size() > 0) checkOutput("t1 loadRunLen", runQ[0], N);
    checkOutput("t1 sortPulses", sortCnt - s0, 1);
    checkOutput("t1 sendPulses", sendCnt - d0, 1);
    compareRun("t1", 1'b1);

    // Test 2: seven nibbles are not enough; the eighth starts LOAD.
    $display("[TB] test 2: partial fill");
    pushRandom(N - 1);
    repeat (12) @(negedge clk);
    checkOutput("t2 noLoad", loadedQ.size(), 0);
    pushRandom(1);
    @(negedge clk);
    checkOutput("t2 loadLowAfterPush", int'(dutLoad), 0);
    @(negedge clk);
    checkOutput("t2 loadRises", int'(dutLoad), 1);
    waitBatchCnt(2, "t2 batch_cnt");
    compareRun("t2", 1'b1);

    // Test 3: 16 back-to-back pushes fill the FIFO while the sorter is busy.
    $display("[TB] test 3: two batches");
    blockReady = 1'b1;
    pushRandom(2 * N);
    checkOutput("t3 inReadyFull", int'(src.ready), 0);
    checkOutput("t3 noLoadWhileBlocked", int'(dutLoad), 0);
    @(negedge clk);
    blockReady = 1'b0;
    waitBatchCnt(4, "t3 batch_cnt");
    checkOutput("t3 inReadyAfter", int'(src.ready), 1);
    compareRun("t3", 1'b1);

    // Test 4: result held until drain_req rises.
    $display("[TB] test 4: drain_req hold");
    drainReq = 1'b0;
    d0 = sendCnt;
    pushRandom(N);
    g = 0;
    while (!sorterWaiting && g < 300) begin
      @(negedge clk);
      g++;
    end
    checkOutput("t4 sorterWaiting", int'(sorterWaiting), 1);
    repeat (20) @(negedge clk);
    checkOutput("t4 noSend", sendCnt - d0, 0);
    checkOutput("t4 stillWaiting", int'(sorterWaiting), 1);
    checkOutput("t4 noOutValid", outQ.size(), 0);
    drainReq = 1'b1;
    @(negedge clk);
    checkOutput("t4 sendPulse", int'(dutSend), 1);
    waitBatchCnt(5, "t4 batch_cnt");
    compareRun("t4", 1'b1);

    // Test 5: sorter never reports Waiting.
    $display("[TB] test 5: sort timeout");
    stubMode = 1'b1;
    pushRandom(N);
    g = 0;
    while (!dutSort && g < 300) begin
      @(negedge clk);
      g++;
    end
    checkOutput("t5 sortSeen", int'(dutSort), 1);
    k = 0;
    while (!sortErr && k < 400) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t5 sortErr", int'(sortErr), 1);
    checkOutput("t5 busyCycles", k, SORT_TMO_MAX + 1);
    repeat (5) @(negedge clk);
    checkOutput("t5 errSticky", int'(sortErr), 1);
    checkOutput("t5 batchUnchanged", int'(batchCnt), 5);
    checkOutput("t5 noOutValid", outQ.size(), 0);
    compareRun("t5", 1'b0);

    // Test 6: reset in the fourth LOAD cycle, then a clean batch.
    $display("[TB] test 6: reset mid-load");
    stubMode = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expQ.delete();
    pushRandom(N);
    g = 0;
    while (!dutLoad && g < 50) begin
      @(negedge clk);
      g++;
    end
    checkOutput("t6 loadSeen", int'(dutLoad), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("t6 reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expQ.delete();
    loadedQ.delete();
    outQ.delete();
    runQ.delete();
    loadsBefore = loadedQ.size();
    pushRandom(N - 1);
    repeat (12) @(negedge clk);
    checkOutput("t6 fifoWasEmpty", loadedQ.size() - loadsBefore, 0);
    pushRandom(1);
    waitBatchCnt(1, "t6 batch_cnt");
    checkOutput("t6 sortErrCleared", int'(sortErr), 0);
    compareRun("t6", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
